// File: rtl/fpu_pkg.sv
// Shared types and helpers for the FPU issue sequencer.
// The optional FPU_TIMEOUT_EN build is handled in the modules that import this package.
package fpu_pkg;

  typedef enum logic [3:0] {
    FP_ADD = 4'd0,
    FP_SUB = 4'd1,
    FP_DIV = 4'd2,
    FP_MUL = 4'd3,
    FP_ABS = 4'd5,
    FP_NEG = 4'd7
  } fpu_funct_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } fpu_issue_state_e;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  // Sign-only ops: the FPU result is valid without waiting for its finish flag.
  function automatic logic is_comb_op(input logic [3:0] funct);
    return (funct == FP_ABS) || (funct == FP_NEG);
  endfunction

  function automatic logic is_arith_op(input logic [3:0] funct);
    return (funct == FP_ADD) || (funct == FP_SUB) ||
           (funct == FP_DIV) || (funct == FP_MUL);
  endfunction

endpackage

// File: rtl/fpu_wait_cnt.sv
// Settle/timeout counter for the WAIT state: synchronous clear, counts while enabled,
// saturates at SAT.
module fpu_wait_cnt #(
  parameter int CNT_W = 7,
  parameter int SAT   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] SAT_C = CNT_W'(SAT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q < SAT_C)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Sequencer between EX and the FPU: latches one op, stalls until the FPU finishes, then
// emits a one-cycle writeback. Define FPU_TIMEOUT_EN to abort ops that never finish.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 64,
  parameter int RD_W    = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic [3:0]      req_funct,
  input  logic [31:0]     req_a,
  input  logic [31:0]     req_b,
  input  logic [RD_W-1:0] req_rd,
  output logic            req_ready,
  output logic            stall,
  output logic [3:0]      fpu_funct,
  output logic [31:0]     fpu_a,
  output logic [31:0]     fpu_b,
  input  logic [31:0]     fpu_o,
  input  logic            fpu_finish,
  output logic            wb_valid,
  output logic [RD_W-1:0] wb_rd,
  output logic [31:0]     wb_data,
  output logic            illegal,
  output logic            timeout
);

  localparam int CNT_MAX = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
  localparam int CNT_W   = $clog2(CNT_MAX + 2);
  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);
`ifdef FPU_TIMEOUT_EN
  localparam int CNT_SAT = TIMEOUT;
  localparam logic [CNT_W-1:0] TMO_LAST_C = CNT_W'(TIMEOUT - 1);
`else
  localparam int CNT_SAT = SETTLE;
`endif

  fpu_issue_state_e state_q, state_d;
  logic [3:0]       funct_q;
  logic [31:0]      a_q, b_q, wb_data_q;
  logic [RD_W-1:0]  rd_q, wb_rd_q;
  logic             illegal_q;
  logic [CNT_W-1:0] cnt;
  logic             accept, fin_ok;
`ifdef FPU_TIMEOUT_EN
  logic             tmo_q, tmo_hit;
`endif

  assign accept = (state_q == ST_IDLE) && req_valid;
  // A finish seen before the settle window may be left over from the previous op.
  assign fin_ok = (cnt >= SETTLE_C) && fpu_finish;
`ifdef FPU_TIMEOUT_EN
  assign tmo_hit = !fin_ok && (cnt >= TMO_LAST_C);
`endif

  fpu_wait_cnt #(.CNT_W(CNT_W), .SAT(CNT_SAT)) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (state_q == ST_ISSUE),
    .en_i  (state_q == ST_WAIT),
    .cnt_o (cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req_valid) state_d = ST_ISSUE;
      ST_ISSUE: state_d = is_arith_op(funct_q) ? ST_WAIT : ST_DONE;
      ST_WAIT: begin
        if (fin_ok) state_d = ST_DONE;
`ifdef FPU_TIMEOUT_EN
        else if (tmo_hit) state_d = ST_DONE;
`endif
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      funct_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      illegal_q <= 1'b0;
`ifdef FPU_TIMEOUT_EN
      tmo_q     <= 1'b0;
`endif
    end else begin
      if (accept) begin
        funct_q   <= req_funct;
        a_q       <= req_a;
        b_q       <= req_b;
        rd_q      <= req_rd;
        illegal_q <= 1'b0;
`ifdef FPU_TIMEOUT_EN
        tmo_q     <= 1'b0;
`endif
      end
      if (state_q == ST_ISSUE) begin
        if (is_comb_op(funct_q)) begin
          wb_data_q <= fpu_o;
          wb_rd_q   <= rd_q;
        end else if (!is_arith_op(funct_q)) begin
          illegal_q <= 1'b1;
        end
      end
      if (state_q == ST_WAIT) begin
        if (fin_ok) begin
          wb_data_q <= fpu_o;
          wb_rd_q   <= rd_q;
        end
`ifdef FPU_TIMEOUT_EN
        else if (tmo_hit) begin
          wb_data_q <= FP_QNAN;
          tmo_q     <= 1'b1;
        end
`endif
      end
    end
  end

  always_comb begin
    req_ready = (state_q == ST_IDLE);
    stall     = (state_q != ST_IDLE);
    wb_valid  = 1'b0;
    illegal   = 1'b0;
    timeout   = 1'b0;
    if (state_q == ST_DONE) begin
      illegal = illegal_q;
`ifdef FPU_TIMEOUT_EN
      wb_valid = !illegal_q && !tmo_q;
      timeout  = tmo_q;
`else
      wb_valid = !illegal_q;
`endif
    end
  end

  assign fpu_funct = funct_q;
  assign fpu_a     = a_q;
  assign fpu_b     = b_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl with a cycle-level expectation model; the timeout
// scenario is added when FPU_TIMEOUT_EN is defined.
module tb_fpu_issue_ctrl;

  localparam int TB_SETTLE = 2;
  localparam int TB_TMO    = 8;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [3:0]  req_funct = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic [4:0]  req_rd = '0;
  logic        req_ready, stall;
  logic [3:0]  fpu_funct;
  logic [31:0] fpu_a, fpu_b;
  logic [31:0] fpu_o = '0;
  logic        fpu_finish = 1'b0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal, timeout;

  fpu_issue_ctrl #(.SETTLE(TB_SETTLE), .TIMEOUT(TB_TMO), .RD_W(5)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_funct(req_funct),
    .req_a(req_a), .req_b(req_b), .req_rd(req_rd), .req_ready(req_ready),
    .stall(stall), .fpu_funct(fpu_funct), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_o(fpu_o), .fpu_finish(fpu_finish), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .illegal(illegal), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  bit chk_en = 1'b0;

  // Model: one op at a time. Busy for cycles (m_acc, m_done]; pulse in m_done by kind
  // (0 writeback, 1 illegal, 2 timeout, 3 aborted). Registered values switch at *_from.
  int m_acc = -10, m_done = -10, m_kind = 3;
  logic [31:0] m_ff_old = '0, m_ff_new = '0, m_fa_old = '0, m_fa_new = '0;
  logic [31:0] m_fb_old = '0, m_fb_new = '0, m_wbd_old = '0, m_wbd_new = '0, m_rd = '0;
  int m_f_from = 0, m_wbd_from = 0;

  // FPU stimulus relative to the accept cycle: finish high for rel in [fs, fs+fl).
  int drv_acc = -1000, drv_fs = 1000, drv_fl = 0;
  logic [31:0] drv_res = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    bit busy;
    int rel;
    bit fin;
    @(negedge clk);
    if (chk_en) begin
      busy = (cyc > m_acc) && (cyc <= m_done);
      chk("req_ready", 32'(req_ready), 32'(!busy));
      chk("stall", 32'(stall), 32'(busy));
      chk("wb_valid", 32'(wb_valid), 32'(cyc == m_done && m_kind == 0));
      chk("illegal", 32'(illegal), 32'(cyc == m_done && m_kind == 1));
      chk("timeout", 32'(timeout), 32'(cyc == m_done && m_kind == 2));
      chk("fpu_funct", 32'(fpu_funct), (cyc >= m_f_from) ? m_ff_new : m_ff_old);
      chk("fpu_a", fpu_a, (cyc >= m_f_from) ? m_fa_new : m_fa_old);
      chk("fpu_b", fpu_b, (cyc >= m_f_from) ? m_fb_new : m_fb_old);
      chk("wb_data", wb_data, (cyc >= m_wbd_from) ? m_wbd_new : m_wbd_old);
      if (cyc == m_done && m_kind == 0) chk("wb_rd", 32'(wb_rd), m_rd);
    end
    rel = cyc - drv_acc;
    fin = (rel >= drv_fs) && (rel < drv_fs + drv_fl);
    fpu_finish = fin;
    fpu_o = (rel == 1 || fin) ? drv_res : 32'hDEAD_BEEF;
  endtask

  task automatic model_op(input logic [3:0] f, input int fs, input int fl);
    bit fin;
    m_done = -1;
    if (f == 4'd5 || f == 4'd7) begin
      m_done = m_acc + 2; m_kind = 0;
    end else if (f <= 4'd3) begin
      for (int k = 0; k < 1000; k++) begin
        fin = (2 + k >= fs) && (2 + k < fs + fl);
        if (k >= TB_SETTLE && fin) begin
          m_done = m_acc + 3 + k; m_kind = 0; break;
        end
`ifdef FPU_TIMEOUT_EN
        if (k == TB_TMO - 1) begin
          m_done = m_acc + 3 + k; m_kind = 2; break;
        end
`endif
      end
    end else begin
      m_done = m_acc + 2; m_kind = 1;
    end
  endtask

  task automatic do_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] res, input int fs,
                       input int fl, input int exp_lat, input int exp_kind, input bit hold);
    int n;
    n = 0;
    while (cyc <= m_done && n < 100) begin tick(); n++; end
    if (n >= 100) chk("idle_wait", 32'(cyc), 32'(m_done + 1));
    req_valid = 1'b1; req_funct = f; req_a = a; req_b = b; req_rd = rd;
    m_ff_old = (cyc >= m_f_from) ? m_ff_new : m_ff_old;
    m_fa_old = (cyc >= m_f_from) ? m_fa_new : m_fa_old;
    m_fb_old = (cyc >= m_f_from) ? m_fb_new : m_fb_old;
    m_ff_new = 32'(f); m_fa_new = a; m_fb_new = b; m_f_from = cyc + 1;
    m_acc = cyc;
    drv_acc = cyc; drv_fs = fs; drv_fl = fl; drv_res = res;
    model_op(f, fs, fl);
    if (m_kind == 0 || m_kind == 2) begin
      m_wbd_old = (cyc >= m_wbd_from) ? m_wbd_new : m_wbd_old;
      m_wbd_new = (m_kind == 0) ? res : QNAN;
      m_wbd_from = m_done;
      m_rd = 32'(rd);
    end
    chk("model_latency", 32'(m_done - m_acc), 32'(exp_lat));
    chk("model_kind", 32'(m_kind), 32'(exp_kind));
    tick();
    if (hold) begin
      req_a = 32'h1234_5678; req_funct = 4'd0; req_rd = 5'd30;
    end else begin
      req_valid = 1'b0;
    end
    n = 0;
    while (cyc < m_done && n < 200) begin tick(); n++; end
    if (exp_kind == 0) begin
      chk("lit_wb_valid", 32'(wb_valid), 32'd1);
      chk("lit_wb_data", wb_data, res);
      chk("lit_wb_rd", 32'(wb_rd), 32'(rd));
    end else if (exp_kind == 1) begin
      chk("lit_illegal", 32'(illegal), 32'd1);
      chk("lit_illegal_nowb", 32'(wb_valid), 32'd0);
    end else begin
      chk("lit_timeout", 32'(timeout), 32'd1);
      chk("lit_timeout_qnan", wb_data, QNAN);
      chk("lit_timeout_nowb", 32'(wb_valid), 32'd0);
    end
    req_valid = 1'b0;
  endtask

  task automatic reset_mid_op();
    int n;
    n = 0;
    while (cyc <= m_done && n < 100) begin tick(); n++; end
    req_valid = 1'b1; req_funct = 4'd2; req_a = 32'h4120_0000; req_b = 32'h4000_0000;
    req_rd = 5'd12;
    m_ff_old = (cyc >= m_f_from) ? m_ff_new : m_ff_old;
    m_fa_old = (cyc >= m_f_from) ? m_fa_new : m_fa_old;
    m_fb_old = (cyc >= m_f_from) ? m_fb_new : m_fb_old;
    m_ff_new = 32'd2; m_fa_new = 32'h4120_0000; m_fb_new = 32'h4000_0000;
    m_f_from = cyc + 1;
    m_acc = cyc;
    drv_acc = cyc; drv_fs = 20; drv_fl = 1; drv_res = 32'h40A0_0000;
    model_op(4'd2, 20, 1);
    chk("model_div_latency", 32'(m_done - m_acc), 32'd21);
    tick();
    req_valid = 1'b0;
    repeat (3) tick();
    // Reset lands in WAIT cycle 2; the op is abandoned after this cycle.
    reset = 1'b1;
    m_done = cyc; m_kind = 3;
    m_ff_old = m_ff_new; m_fa_old = m_fa_new; m_fb_old = m_fb_new;
    m_ff_new = '0; m_fa_new = '0; m_fb_new = '0; m_f_from = cyc + 1;
    m_wbd_old = (cyc >= m_wbd_from) ? m_wbd_new : m_wbd_old;
    m_wbd_new = '0; m_wbd_from = cyc + 1;
    tick();
    reset = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_fpu_a", fpu_a, 32'd0);
    chk("rst_fpu_funct", 32'(fpu_funct), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    repeat (20) tick();
  endtask

  initial begin
    tick();
    chk_en = 1'b1;
    tick();
    chk("init_req_ready", 32'(req_ready), 32'd1);
    chk("init_stall", 32'(stall), 32'd0);
    chk("init_wb_data", wb_data, 32'd0);
    chk("init_wb_rd", 32'(wb_rd), 32'd0);
    reset = 1'b0;
    tick();
    //     funct  a              b              rd     result         fs  fl    lat kind hold
    do_op(4'd0, 32'h3F80_0000, 32'h4000_0000, 5'd4,  32'h4040_0000, 6,  1,    7,  0,   1'b0);
    do_op(4'd7, 32'h3F80_0000, 32'h0000_0000, 5'd9,  32'hBF80_0000, 0,  0,    2,  0,   1'b0);
    do_op(4'd3, 32'h4000_0000, 32'h4040_0000, 5'd3,  32'h40C0_0000, 1,  1000, 5,  0,   1'b0);
    do_op(4'd4, 32'h3F80_0000, 32'h3F80_0000, 5'd7,  32'h0000_0000, 0,  0,    2,  1,   1'b0);
    do_op(4'd5, 32'hBF80_0000, 32'h0000_0000, 5'd1,  32'h3F80_0000, 0,  0,    2,  0,   1'b1);
    do_op(4'd1, 32'h40A0_0000, 32'h3F80_0000, 5'd17, 32'h4080_0000, 3,  2,    5,  0,   1'b0);
    do_op(4'd15, 32'h1111_1111, 32'h2222_2222, 5'd2, 32'h0000_0000, 0,  0,    2,  1,   1'b0);
    reset_mid_op();
    do_op(4'd2, 32'h4100_0000, 32'h4000_0000, 5'd31, 32'h4080_0000, 8,  1,    9,  0,   1'b0);
`ifdef FPU_TIMEOUT_EN
    do_op(4'd0, 32'h3F80_0000, 32'h3F80_0000, 5'd6,  32'h4000_0000, 0,  0,    10, 2,   1'b0);
`endif
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
Pipeline-side sequencer directly upstream of the FPU.
- Accepts one FP operation from the EX stage and registers operands/funct into the FPU inputs, holding them stable for the whole operation.
- Stalls the pipeline while waiting for the FPU finish flag, then captures the FPU result and presents a one-cycle writeback to the register file.

Parameters:
SETTLE, 2, cycles in WAIT during which fpu_finish is ignored (masks stale finish from the previous op)
TIMEOUT, 64, max WAIT cycles before abort (used only with FPU_TIMEOUT_EN)
RD_W, 5, destination register index width

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  EX stage presents an FP op
req_funct  in  4  0 add, 1 sub, 2 div, 3 mul, 5 abs, 7 neg
req_a  in  32  operand a, IEEE-754 single
req_b  in  32  operand b
req_rd  in  RD_W  destination register
req_ready  out  1  high only in IDLE
stall  out  1  high whenever state != IDLE
fpu_funct  out  4  registered funct to FPU
fpu_a  out  32  registered operand a
fpu_b  out  32  registered operand b
fpu_o  in  32  FPU result
fpu_finish  in  1  FPU done flag
wb_valid  out  1  one-cycle writeback strobe
wb_rd  out  RD_W  writeback register
wb_data  out  32  captured result
illegal  out  1  one-cycle pulse, unsupported funct
timeout  out  1  one-cycle pulse, FPU abort (tied 0 without macro)

Behaviour:
- Reset (synchronous, active-high): state IDLE; all outputs 0 except req_ready=1. Reset mid-operation abandons the op: no wb_valid, fpu_* cleared to 0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE, accept on req_valid & req_ready:
  - Register funct/a/b into fpu_* and rd into an internal rd_q.
  - Go to ISSUE.
  - fpu_* hold their value until the next accept.
- ISSUE, one cycle:
  - funct 5/7: capture fpu_o, go to DONE.
  - funct 0-3: clear the wait counter, go to WAIT.
  - Any other funct: set the illegal flag and go to DONE without capturing.
  - fpu_finish is ignored in ISSUE.
- WAIT:
  - Counter increments every cycle.
  - If counter >= SETTLE and fpu_finish=1: capture fpu_o, go to DONE.
  - finish arriving before SETTLE is ignored; it must still be high at or after SETTLE.
- DONE, one cycle:
  - Normal op: wb_valid=1, wb_rd=rd_q, wb_data=captured value.
  - Illegal op: illegal=1, wb_valid=0.
  - Then go to IDLE.
- Output timing:
  - wb_data and wb_rd hold their value after DONE until the next capture.
  - wb_valid, illegal and timeout are single-cycle pulses.
- Latency from the accept edge:
  - abs/neg: wb_valid in cycle +2.
  - Arithmetic: >= SETTLE+3 cycles.
- req_valid while stalled is ignored; the EX stage must hold the request.
- Back-to-back: a new request can be accepted in the cycle after DONE.

Optional Feature:
FPU_TIMEOUT_EN
- Defined: if the WAIT counter reaches TIMEOUT without a qualifying finish, go to DONE with wb_valid=0, timeout=1, wb_data=32'h7FC00000 (quiet NaN).
- Undefined: WAIT waits indefinitely, the timeout port is tied 0, and the counter saturates at SETTLE.

Decomposition:
- Package fpu_pkg:
  - Enum fpu_funct_e (FP_ADD=0, FP_SUB=1, FP_DIV=2, FP_MUL=3, FP_ABS=5, FP_NEG=7).
  - Enum fpu_issue_state_e.
  - Constant FP_QNAN=32'h7FC00000.
  - Helper function is_comb_op(funct).
- Optional single sub-module fpu_wait_cnt: settle/timeout counter with clear and saturation. Everything else is flat.

Test Plan:
1. add: a=3F800000, b=40000000, funct 0, rd 4; model FPU gives fpu_o=40400000 with finish 5 cycles after ISSUE -> one wb_valid, wb_rd=4, wb_data=40400000; stall high from accept+1 through DONE; req_ready low the same cycles.
2. neg: a=3F800000, funct 7, rd 9 -> wb_valid at accept+2, wb_data=BF800000; stall high for exactly 2 cycles.
3. Stale finish: fpu_finish held high, SETTLE=2, mul -> capture exactly at WAIT cycle 2, not earlier; wb_valid 5 cycles after accept.
4. Illegal: funct 4 -> illegal pulse 1 cycle at accept+2, wb_valid stays 0, back to IDLE at accept+3.
5. Reset mid-op: assert reset during WAIT of a div -> next cycle IDLE, req_ready=1, fpu_*=0, and no wb_valid even if finish arrives later.
6. With FPU_TIMEOUT_EN, TIMEOUT=8: finish never asserted -> timeout pulse after 8 WAIT cycles, wb_data=7FC00000, wb_valid=0.
